// File: rtl/fp_op_sequencer.sv
// Request/response sequencer for the shared add/mul/div fixed-point units.
// Accepts one operation at a time, drives the units, and returns a registered result.
module fp_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_opcode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] add_result,
  input  logic [WIDTH-1:0] mul_result,
  output logic             div_start,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_DIV,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      opcode_q;
  logic [TW-1:0]   tmo_cnt;
  logic            accept;
  logic            handshake;
  logic            div_fire;
  logic            tmo_hit;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_RESP);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // A done that arrives while the start pulse is still high belongs to no
  // operation of ours, so it is masked.
  assign div_fire = (state == S_WAIT_DIV) && !div_start && div_done;
  // tmo_cnt counts completed WAIT_DIV cycles; this fires on the edge that
  // ends the DIV_TIMEOUT-th cycle.
  assign tmo_hit  = (state == S_WAIT_DIV) && (tmo_cnt == TW'(DIV_TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (in_opcode)
            2'b00, 2'b01: state_nxt = S_EXEC;
            2'b10:        state_nxt = S_WAIT_DIV;
            default:      state_nxt = S_RESP;
          endcase
        end
      end
      S_EXEC:     state_nxt = S_RESP;
      S_WAIT_DIV: if (div_fire || tmo_hit) state_nxt = S_RESP;
      S_RESP:     if (out_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      opcode_q   <= 2'b00;
      div_start  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      tmo_cnt    <= '0;
      op_count   <= '0;
    end else begin
      div_start <= accept && (in_opcode == 2'b10);

      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        opcode_q <= in_opcode;
        if (in_opcode == 2'b11) begin
          out_result <= '0;
          out_err    <= 1'b1;
        end
      end

      if (state == S_EXEC) begin
        out_result <= opcode_q[0] ? mul_result : add_result;
        out_err    <= 1'b0;
      end

      if (div_fire) begin
        out_result <= div_result;
        out_err    <= 1'b0;
      end else if (tmo_hit) begin
        out_result <= '0;
        out_err    <= 1'b1;
      end

      if ((state == S_WAIT_DIV) && (state_nxt == S_WAIT_DIV)) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (handshake) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer: behavioural adder/multiplier, a scripted
// divider, and hand-computed expectations for each scenario.
module tb_fp_op_sequencer;

  localparam int WIDTH = 32;
  localparam int TMO   = 64;
  // Narrow counter keeps the wrap scenario short.
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_opcode;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_result, mul_result, div_result;
  logic             div_start, div_done;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [CW-1:0]    op_count;

  int checks   = 0;
  int failures = 0;
  int start_pulses = 0;
  int overlap_seen = 0;
  logic [CW-1:0] exp_count;

  always #5 clk = ~clk;

  assign add_result = op_a + op_b;
  assign mul_result = op_a * op_b;

  always @(posedge clk) if (div_start) start_pulses++;
  always @(negedge clk) if (in_ready && out_valid) overlap_seen++;

  fp_op_sequencer #(.WIDTH(WIDTH), .DIV_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .op_a(op_a), .op_b(op_b),
    .add_result(add_result), .mul_result(mul_result),
    .div_start(div_start), .div_result(div_result), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err),
    .op_count(op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns 1ns after the accepting edge.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    in_valid = 1'b1; in_a = a; in_b = b; in_opcode = op;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = 2'b00;
    out_ready = 1'b0; div_done = 1'b0; div_result = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    exp_count = '0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({op_a, op_b, out_result} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {op_a, op_b, out_result}); end
    checks++; if ({div_start, out_err} !== 2'b00 || op_count !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%b/%h exp=00/00", {div_start, out_err}, op_count); end
  endtask

  task automatic test_add();
    do_accept(32'h0080_0000, 32'h0100_0000, 2'b00);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL add_exec_cycle got=%b%b exp=00", out_valid, in_ready); end
    checks++; if (op_a !== 32'h0080_0000 || op_b !== 32'h0100_0000) begin failures++; $display("FAIL add_operands got=%h/%h exp=00800000/01000000", op_a, op_b); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0180_0000 || out_err !== 1'b0) begin failures++; $display("FAIL add_result got=%b %h %b exp=1 01800000 0", out_valid, out_result, out_err); end
    checks++; if (op_count !== exp_count) begin failures++; $display("FAIL add_count_before got=%h exp=%h", op_count, exp_count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count++;
    checks++; if (op_count !== exp_count || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL add_handshake got=%h %b %b exp=%h 0 1", op_count, out_valid, in_ready, exp_count); end
  endtask

  task automatic test_mul();
    do_accept(32'h0000_1234, 32'h0000_0010, 2'b01);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0001_2340 || out_err !== 1'b0) begin failures++; $display("FAIL mul_result got=%b %h %b exp=1 00012340 0", out_valid, out_result, out_err); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; exp_count++;
    checks++; if (op_count !== exp_count) begin failures++; $display("FAIL mul_count got=%h exp=%h", op_count, exp_count); end
  endtask

  task automatic test_div_backpressure();
    int s0;
    logic stable_ok;
    s0 = start_pulses;
    // A done coinciding with the start pulse must be ignored.
    div_done = 1'b1; div_result = 32'hBAD0_0BAD;
    do_accept(32'h0100_0000, 32'h0400_0000, 2'b10);
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL div_start_pulse got=%b exp=1", div_start); end
    tick();
    div_done = 1'b0;
    checks++; if (div_start !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL div_early_done got=%b%b exp=00", div_start, out_valid); end
    repeat (18) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL div_not_yet got=%b exp=0", out_valid); end
    div_done = 1'b1; div_result = 32'h0040_0000;
    tick();
    div_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0040_0000 || out_err !== 1'b0) begin failures++; $display("FAIL div_result got=%b %h %b exp=1 00400000 0", out_valid, out_result, out_err); end
    stable_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      div_done = 1'b1; div_result = 32'h1111_1111 * i;
      tick();
      if (out_valid !== 1'b1 || out_result !== 32'h0040_0000 || out_err !== 1'b0 || in_ready !== 1'b0 || op_count !== exp_count) stable_ok = 1'b0;
    end
    div_done = 1'b0;
    checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL div_stall_stable got=%b exp=1", stable_ok); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; exp_count++;
    checks++; if (op_count !== exp_count || out_valid !== 1'b0) begin failures++; $display("FAIL div_count got=%h %b exp=%h 0", op_count, out_valid, exp_count); end
    checks++; if (start_pulses - s0 !== 1) begin failures++; $display("FAIL div_start_count got=%0d exp=1", start_pulses - s0); end
  endtask

  task automatic test_div_timeout();
    do_accept(32'h0000_0009, 32'h0000_0000, 2'b10);
    repeat (TMO - 1) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_err !== 1'b1) begin failures++; $display("FAIL tmo_resp got=%b %h %b exp=1 00000000 1", out_valid, out_result, out_err); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; exp_count++;
    checks++; if (op_count !== exp_count) begin failures++; $display("FAIL tmo_count got=%h exp=%h", op_count, exp_count); end
  endtask

  task automatic test_done_beats_timeout();
    do_accept(32'h0000_0007, 32'h0000_0001, 2'b10);
    repeat (TMO - 1) tick();
    div_done = 1'b1; div_result = 32'h0000_0055;
    tick();
    div_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0055 || out_err !== 1'b0) begin failures++; $display("FAIL done_wins got=%b %h %b exp=1 00000055 0", out_valid, out_result, out_err); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; exp_count++;
  endtask

  task automatic test_illegal();
    int s0;
    s0 = start_pulses;
    do_accept(32'hDEAD_BEEF, 32'h0000_0001, 2'b11);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_err !== 1'b1) begin failures++; $display("FAIL illegal_resp got=%b %h %b exp=1 00000000 1", out_valid, out_result, out_err); end
    checks++; if (op_a !== 32'hDEAD_BEEF || div_start !== 1'b0) begin failures++; $display("FAIL illegal_opa got=%h %b exp=deadbeef 0", op_a, div_start); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; exp_count++;
    checks++; if (op_count !== exp_count || start_pulses != s0) begin failures++; $display("FAIL illegal_count got=%h/%0d exp=%h/0", op_count, start_pulses - s0, exp_count); end
  endtask

  task automatic test_reset_mid_divide();
    do_accept(32'h0000_00AA, 32'h0000_0003, 2'b10);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, div_start, out_err, in_ready} !== 4'b0000) begin failures++; $display("FAIL rst_async_ctrl got=%b exp=0000", {out_valid, div_start, out_err, in_ready}); end
    checks++; if (op_a !== 32'h0 || out_result !== 32'h0 || op_count !== 8'h00) begin failures++; $display("FAIL rst_async_data got=%h %h %h exp=0 0 0", op_a, out_result, op_count); end
    tick();
    rst = 1'b0;
    exp_count = '0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    div_done = 1'b1; div_result = 32'h0000_0077;
    repeat (3) tick();
    div_done = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_late_done got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int bad_res = 0;
    int bad_thru = 0;
    logic [31:0] exp_res;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 2'b01;
    for (int i = 0; i < 256; i++) begin
      in_a = 32'(i); in_b = 32'd3;
      exp_res = 32'(i * 3);
      if (in_ready !== 1'b1) bad_thru++;
      tick();
      if (out_valid !== 1'b0) bad_thru++;
      tick();
      if (out_valid !== 1'b1 || out_result !== exp_res) bad_res++;
      tick();
      exp_count++;
      if (i == 254) begin
        checks++; if (op_count !== 8'hFF) begin failures++; $display("FAIL b2b_all_ones got=%h exp=ff", op_count); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (bad_res != 0) begin failures++; $display("FAIL b2b_results got=%0d bad exp=0", bad_res); end
    checks++; if (bad_thru != 0) begin failures++; $display("FAIL b2b_throughput got=%0d bad exp=0", bad_thru); end
    checks++; if (op_count !== 8'h00 || exp_count !== 8'h00) begin failures++; $display("FAIL b2b_wrap got=%h exp=00", op_count); end
    checks++; if (overlap_seen != 0) begin failures++; $display("FAIL ready_valid_overlap got=%0d exp=0", overlap_seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_backpressure();
    test_div_timeout();
    test_done_beats_timeout();
    test_illegal();
    test_reset_mid_divide();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
- Sequences one arithmetic operation at a time onto the shared fixed-point unit set: single-cycle combinational adder, single-cycle combinational multiplier, multi-cycle divider with start/complete handshake.
- Upstream side: valid/ready request channel. Downstream side: valid/ready response channel.
- Latches operands, pulses the divider start, waits for completion with a timeout, selects the correct unit result, and counts completed operations.
- Sits between the test/host driver and the arithmetic units, replacing direct opcode muxing at the top level.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIV_TIMEOUT, 64, maximum cycles to wait for div_done after div_start before aborting.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_opcode  input  2  operation select: 00 add, 01 mul, 10 div, 11 illegal.
- op_a  output  WIDTH  registered operand A driven to all units.
- op_b  output  WIDTH  registered operand B driven to all units.
- add_result  input  WIDTH  adder output (combinational from op_a/op_b).
- mul_result  input  WIDTH  multiplier output (combinational from op_a/op_b).
- div_start  output  1  one-cycle divider start pulse.
- div_result  input  WIDTH  divider quotient.
- div_done  input  1  divider completion flag.
- out_valid  output  1  response valid.
- out_ready  input  1  downstream accepts response.
- out_result  output  WIDTH  registered result.
- out_err  output  1  response is an error (illegal opcode or divider timeout).
- op_count  output  CNT_W  number of responses consumed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, any state, including mid-divide):
  - State goes to IDLE.
  - op_a, op_b, out_result, op_count = 0.
  - div_start, out_valid, out_err = 0.
  - Timeout counter = 0.
  - in_ready = 1 after reset deasserts.
- States:
  - IDLE: in_ready = 1 only here; no request overlap.
  - EXEC: add/mul result capture cycle.
  - WAIT_DIV: divider in progress.
  - RESP: response held for downstream.
- Accept (edge T, IDLE with in_valid = 1):
  - in_a/in_b latched into op_a/op_b; opcode latched internally.
  - Next state by opcode:
    - 00/01 → EXEC.
    - 10 → WAIT_DIV, with div_start = 1 for exactly the cycle after T.
    - 11 → RESP, with out_result = 0 and out_err = 1.
- EXEC (edge T+1):
  - out_result captures add_result or mul_result; out_err = 0; → RESP.
  - out_valid is high from T+1. Add/mul latency is 2 edges from accept.
- WAIT_DIV:
  - The timeout counter increments each cycle in this state.
  - div_done is sampled starting the cycle after the div_start pulse. A done coinciding with the start pulse is ignored.
  - On div_done = 1: out_result = div_result, out_err = 0, → RESP.
  - On counter == DIV_TIMEOUT with no done: out_result = 0, out_err = 1, → RESP.
  - If done and timeout occur on the same edge, done wins.
  - The counter clears on leaving the state.
- RESP:
  - out_valid = 1; out_result and out_err are held stable while out_ready = 0.
  - On out_valid & out_ready: op_count increments (wrapping all-ones → 0), out_valid drops, → IDLE.
  - in_ready rises the following cycle, so back-to-back throughput is one operation per 3 cycles minimum for add/mul.
- Other rules:
  - div_done outside WAIT_DIV is ignored.
  - op_a/op_b change only on accept.
  - Error responses also increment op_count when consumed.
  - in_opcode and operands are don't-care when in_valid = 0 or in_ready = 0.

Test Plan:
- Reset mid-divide: assert rst 5 cycles into WAIT_DIV → all outputs 0 immediately (asynchronous), in_ready = 1 after release. A late div_done then produces no response.
- Add: in_a = 32'h0080_0000, in_b = 32'h0100_0000, opcode 00, adder model returns 32'h0180_0000 → out_valid 2 edges after accept, out_result = 32'h0180_0000, out_err = 0, op_count 0→1 on handshake.
- Divide with backpressure: opcode 10, divider model asserts done after 20 cycles with div_result = 32'h0040_0000; out_ready held low 7 cycles → exactly one div_start pulse, result stable through the stall, single count increment.
- Divider timeout: opcode 10 and div_done never asserted → RESP after DIV_TIMEOUT (64) cycles in WAIT_DIV, out_result = 0, out_err = 1.
- Illegal opcode 11 with in_a = 32'hDEAD_BEEF → out_result = 0, out_err = 1, no div_start pulse, op_a = 32'hDEAD_BEEF.
- Counter wrap: preload via 65536 back-to-back mul ops with out_ready tied high → op_count returns to 0. in_ready is never high while out_valid is high.
